// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - radix-2 DIT in-place FFT butterfly address sequencer
module fft_addr_gen #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pnt_cfg,
  input  logic        start,
  input  logic        abort,
  input  logic        bf_ready,
  output logic        bf_valid,
  output logic [9:0]  addr_a,
  output logic [9:0]  addr_b,
  output logic [8:0]  tw_idx,
  output logic [3:0]  stage,
  output logic        last_in_stage,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]    log_n;
  logic [3:0]    log_n_cfg;
  logic [3:0]    stg;
  logic [8:0]    bf;
  logic [DW-1:0] drain_cnt;
  logic          cfg_legal;
  logic          cfg_err_q;
  logic          bf_last;
  logic          stage_last;
  logic          hs;
  logic          drain_end;

  logic [9:0]    bf_ext;
  logic [9:0]    span;
  logic [9:0]    lo_mask;
  logic [8:0]    j_bits;
  logic [9:0]    a_raw;
  logic [3:0]    tw_sh;

  always_comb begin
    cfg_legal = 1'b1;
    log_n_cfg = 4'd0;
    case (pnt_cfg)
      11'd8:    log_n_cfg = 4'd3;
      11'd16:   log_n_cfg = 4'd4;
      11'd32:   log_n_cfg = 4'd5;
      11'd64:   log_n_cfg = 4'd6;
      11'd128:  log_n_cfg = 4'd7;
      11'd256:  log_n_cfg = 4'd8;
      11'd512:  log_n_cfg = 4'd9;
      11'd1024: log_n_cfg = 4'd10;
      default:  cfg_legal = 1'b0;
    endcase
  end

  // bf_last compares against N/2-1, built from a right-shifted all-ones mask
  assign bf_last    = (bf == (9'h1FF >> (4'd10 - log_n)));
  assign stage_last = (stg == (log_n - 4'd1));
  assign hs         = (state == S_RUN) && bf_ready;
  assign drain_end  = (drain_cnt == DRAIN_LAST);

  // Butterfly index bf becomes addr_a by inserting a 0 bit at position stg
  assign bf_ext  = {1'b0, bf};
  assign span    = 10'd1 << stg;
  assign lo_mask = span - 10'd1;
  assign j_bits  = bf & lo_mask[8:0];
  assign a_raw   = ((bf_ext & ~lo_mask) << 1) | {1'b0, j_bits};
  assign tw_sh   = log_n - 4'd1 - stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && cfg_legal) state_nxt = S_RUN;
      S_RUN: begin
        if (hs && bf_last) begin
          if (DRAIN_CYCLES > 0) state_nxt = S_DRAIN;
          else if (stage_last)  state_nxt = S_DONE;
        end
      end
      S_DRAIN: if (drain_end) state_nxt = stage_last ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // stg advances when the stage fully retires (after drain), so DRAIN still sees the finished stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_n     <= 4'd0;
      stg       <= 4'd0;
      bf        <= 9'd0;
      drain_cnt <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == S_IDLE) && start && !cfg_legal;
      case (state)
        S_IDLE: begin
          if (start && cfg_legal) begin
            log_n     <= log_n_cfg;
            stg       <= 4'd0;
            bf        <= 9'd0;
            drain_cnt <= '0;
          end
        end
        S_RUN: begin
          if (hs && !abort) begin
            if (!bf_last) begin
              bf <= bf + 9'd1;
            end else begin
              bf        <= 9'd0;
              drain_cnt <= '0;
              if (DRAIN_CYCLES == 0) stg <= stg + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!abort) begin
            if (drain_end) stg       <= stg + 4'd1;
            else           drain_cnt <= drain_cnt + DRAIN_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bf_valid      = (state == S_RUN);
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    cfg_err       = cfg_err_q;
    addr_a        = 10'd0;
    addr_b        = 10'd0;
    tw_idx        = 9'd0;
    stage         = 4'd0;
    last_in_stage = 1'b0;
    if (state == S_RUN) begin
      addr_a        = a_raw;
      addr_b        = a_raw | span;
      tw_idx        = j_bits << tw_sh;
      stage         = stg;
      last_in_stage = bf_last;
    end
  end

endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

Radix-2 decimation-in-time butterfly address sequencer for the in-place FFT datapath. It sits directly downstream of the point-configuration register and consumes its 11-bit transform size N (8..1024, one-hot power of two). On `start` it walks all log2(N) stages and emits one butterfly per accepted handshake: two memory addresses plus a twiddle index. It inserts a configurable drain gap between stages so the butterfly pipeline can retire writes before the next stage reads them.

## Interface
- `DRAIN_CYCLES`, default 4: idle cycles inserted after the last accepted butterfly of every stage (0 is legal).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pnt_cfg` input 11: transform size N; the configuration register output.
- `start` input 1: single-cycle request to begin a transform. Honoured only in IDLE.
- `abort` input 1: synchronous cancel of the current transform.
- `bf_ready` input 1: downstream butterfly unit accepts the current output.
- `bf_valid` output 1: `addr_a`, `addr_b`, `tw_idx`, `stage` and `last_in_stage` are valid.
- `addr_a` output 10: upper-input address of the butterfly.
- `addr_b` output 10: lower-input address; always `addr_a + 2^stage`.
- `tw_idx` output 9: twiddle ROM index, in units of W_N.
- `stage` output 4: current stage, 0..L-1, where L = log2(N).
- `last_in_stage` output 1: the current butterfly is the last of its stage.
- `busy` output 1: a transform is in progress.
- `done` output 1: one-cycle pulse when the transform completes.
- `cfg_err` output 1: one-cycle pulse when `start` arrives with an illegal `pnt_cfg`.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Reset:** all outputs are 0, state is IDLE, and all internal counters are 0.
- **IDLE, `start`=1, `pnt_cfg` legal:**
  - latch N;
  - compute L (3..10);
  - clear stage and butterfly counter `bf`;
  - go to RUN.
  - Legal values are exactly 8, 16, 32, 64, 128, 256, 512, 1024.
- **IDLE, `start`=1, `pnt_cfg` illegal** (e.g. 0, 4, 24, 2047): pulse `cfg_err` for one cycle and stay in IDLE.
- **Address generation in RUN** (`bf` ranges 0..N/2-1, s = stage):
  - j = `bf` & (2^s - 1)
  - `addr_a` = ((`bf` >> s) << (s+1)) | j, i.e. a 0 bit inserted at position s
  - `addr_b` = `addr_a` | 2^s
  - `tw_idx` = j << (L-1-s)
  - Upper address bits beyond L-1 are always 0.
- **Handshake:**
  - Outputs are registered and held stable while `bf_valid`=1 and `bf_ready`=0.
  - The sequencer advances only on `bf_valid` & `bf_ready`.
- **Last butterfly of a stage** (`bf` = N/2-1) accepted:
  - if DRAIN_CYCLES > 0: go to DRAIN, `bf_valid`=0 for DRAIN_CYCLES cycles;
  - if DRAIN_CYCLES = 0: go straight to the next stage, or to DONE.
  - Then stage+1 with `bf`=0 returns to RUN; if stage was L-1, go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`abort`:** in RUN, DRAIN or DONE, the next state is IDLE with `bf_valid`=0 and `busy`=0; `done` is not pulsed. `abort` has priority over a handshake in the same cycle.
- **`start` outside IDLE:** ignored; no error is flagged.
- `pnt_cfg` changes after `start` have no effect on the transform in progress.

## Timing
- `start` sampled at cycle t: `bf_valid` and `busy` are high at t+1 with the first butterfly.
- With `bf_ready` tied to 1:
  - one butterfly is produced per cycle;
  - `done` is high at cycle t + L·(N/2 + DRAIN_CYCLES) + 1;
  - `busy` is high from t+1 through the `done` cycle and low the cycle after.
- `start` in the same cycle as `done` is ignored, because the block is not yet in IDLE.
- A `start` is accepted one cycle after `done` at the earliest.
- `rst_n` asserted mid-transform: all outputs clear immediately and asynchronously; no `done` is produced.
- `cfg_err` rises at t+1 and `busy` stays 0.

## Test plan
- **N=8, DRAIN_CYCLES=4, `bf_ready`=1, start at cycle 0** → (a,b,tw) sequence:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - `done` at cycle 25; `last_in_stage` on the 4th butterfly of each stage.
- **N=1024, `bf_ready`=1** → 5120 butterflies in total.
  - The last butterfly is a=511, b=1023, tw=511, stage=9.
  - `done` at cycle 10·(512+4)+1 = 5161.
- **N=16, `bf_ready` toggling pseudo-randomly** → outputs held while `bf_ready`=0; no butterfly is skipped or duplicated; the sequence matches the golden model.
- **Illegal config** → `start` with `pnt_cfg` = 24, and then with 4, gives a `cfg_err` pulse and `busy`=0. A following `start` with 32 runs normally.
- **`abort` during stage 1 of N=64, coincident with a handshake** → IDLE next cycle, no `done`. A new `start` begins again at stage 0, `bf` 0.
- **DRAIN_CYCLES=0, N=8** → 12 consecutive valid cycles with no gaps; `done` at cycle 13.
- **`rst_n` pulsed low mid-stage** → all outputs 0 immediately and state IDLE.
